store_fram_fsm: RTL

Write-back sequencer for the NP811 PFPGA FRAM. On a start pulse it drives the two FRAM write engines in order: constants first, then the AFPGA image. It retries failed or timed-out stages, aborts on a flash-side error and reports a single done or error pulse with a cause code. It is the store-direction counterpart of the FRAM load sequencer and sits beside it under the board control logic.

---
 rtl/store_fram_fsm_if.sv | 35 +++
 rtl/store_fram_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/store_fram_fsm_if.sv
// Store sequencer bundle: start/abort from board control, status back, and both FRAM write engine handshakes.
// Latency: none, wires only.
// Backpressure: none; engines answer with done/error pulses and the sequencer enforces its own timeout.
interface store_fram_fsm_if;
  logic       store_ram_en;
  logic       flash_fsm_error;
  logic       store_busy;
  logic       fram_fsm_done;
  logic       fram_fsm_error;
  logic [2:0] fram_err_code;
  logic       fram_cons_wr_en;
  logic       fram_cons_wr_done;
  logic       fram_cons_wr_error;
  logic       fram_afpga_wr_en;
  logic       fram_afpga_wr_done;
  logic       fram_afpga_wr_error;

  // Board control plus write engines: drive start, abort and engine responses.
  modport master (
    output store_ram_en, flash_fsm_error,
    output fram_cons_wr_done, fram_cons_wr_error,
    output fram_afpga_wr_done, fram_afpga_wr_error,
    input  store_busy, fram_fsm_done, fram_fsm_error, fram_err_code,
    input  fram_cons_wr_en, fram_afpga_wr_en
  );

  // The sequencer itself.
  modport slave (
    input  store_ram_en, flash_fsm_error,
    input  fram_cons_wr_done, fram_cons_wr_error,
    input  fram_afpga_wr_done, fram_afpga_wr_error,
    output store_busy, fram_fsm_done, fram_fsm_error, fram_err_code,
    output fram_cons_wr_en, fram_afpga_wr_en
  );
endinterface

// File: rtl/store_fram_fsm.sv
// FRAM write-back sequencer: constants engine then AFPGA engine, with per-stage retry/timeout and abort.
// Latency: 6 cycles start-to-done minimum; all outputs are registered (one cycle behind the state).
// Backpressure: starts outside IDLE are dropped; engine responses outside their WAIT state are ignored.
module store_fram_fsm #(
  parameter int unsigned          TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 20'd1000000,
  parameter int unsigned          MAX_RETRY   = 2
) (
  input  logic          sys_clk,
  input  logic          glbl_rst_n,
  store_fram_fsm_if.slave bus
);

  localparam int unsigned          RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_CYC - TIMEOUT_W'(1);

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_CONS_ERR  = 3'd1;
  localparam logic [2:0] CODE_CONS_TMO  = 3'd2;
  localparam logic [2:0] CODE_AFPGA_ERR = 3'd3;
  localparam logic [2:0] CODE_AFPGA_TMO = 3'd4;
  localparam logic [2:0] CODE_FLASH     = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONS_REQ   = 3'd1,
    CONS_WAIT  = 3'd2,
    AFPGA_REQ  = 3'd3,
    AFPGA_WAIT = 3'd4,
    DONE       = 3'd5,
    ERR        = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [2:0]           cause_q, cause_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 cons_en_q, cons_en_d;
  logic                 afpga_en_q, afpga_en_d;

  logic                 fail;
  logic [2:0]           fail_code;
  state_e               retry_state;

  // State and bookkeeping registers.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q <= IDLE;
      retry_q <= '0;
      tmo_q   <= '0;
      cause_q <= CODE_NONE;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
    end
  end

  // Next state: WAIT priority is abort, engine error, engine done, timeout; failures share one retry path.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    cause_d     = cause_q;
    fail        = 1'b0;
    fail_code   = CODE_NONE;
    retry_state = IDLE;
    case (state_q)
      IDLE: begin
        if (bus.store_ram_en) begin
          state_d = CONS_REQ;
          retry_d = '0;
          tmo_d   = '0;
          cause_d = CODE_NONE;
        end
      end
      CONS_REQ: begin
        tmo_d   = '0;
        state_d = CONS_WAIT;
      end
      CONS_WAIT: begin
        retry_state = CONS_REQ;
        if (bus.flash_fsm_error) begin
          state_d = ERR;
          cause_d = CODE_FLASH;
        end else if (bus.fram_cons_wr_error) begin
          fail      = 1'b1;
          fail_code = CODE_CONS_ERR;
        end else if (bus.fram_cons_wr_done) begin
          state_d = AFPGA_REQ;
          retry_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          fail      = 1'b1;
          fail_code = CODE_CONS_TMO;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      AFPGA_REQ: begin
        tmo_d   = '0;
        state_d = AFPGA_WAIT;
      end
      AFPGA_WAIT: begin
        retry_state = AFPGA_REQ;
        if (bus.flash_fsm_error) begin
          state_d = ERR;
          cause_d = CODE_FLASH;
        end else if (bus.fram_afpga_wr_error) begin
          fail      = 1'b1;
          fail_code = CODE_AFPGA_ERR;
        end else if (bus.fram_afpga_wr_done) begin
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          fail      = 1'b1;
          fail_code = CODE_AFPGA_TMO;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = retry_state;
      end else begin
        state_d = ERR;
        cause_d = fail_code;
      end
    end
  end

  // Outputs decoded from the current state; busy stays up through the final done/error pulse.
  always_comb begin
    cons_en_d  = (state_q == CONS_REQ);
    afpga_en_d = (state_q == AFPGA_REQ);
    done_d     = (state_q == DONE);
    error_d    = (state_q == ERR);
    busy_d     = (state_d != IDLE) || done_d || error_d;
    err_code_d = err_code_q;
    if (state_q == ERR) begin
      err_code_d = cause_q;
    end else if ((state_q == IDLE) && bus.store_ram_en) begin
      err_code_d = CODE_NONE;
    end
  end

  // Output registers so every pulse is glitch-free and exactly one cycle wide.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= CODE_NONE;
      cons_en_q  <= 1'b0;
      afpga_en_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      cons_en_q  <= cons_en_d;
      afpga_en_q <= afpga_en_d;
    end
  end

  assign bus.store_busy       = busy_q;
  assign bus.fram_fsm_done    = done_q;
  assign bus.fram_fsm_error   = error_q;
  assign bus.fram_err_code    = err_code_q;
  assign bus.fram_cons_wr_en  = cons_en_q;
  assign bus.fram_afpga_wr_en = afpga_en_q;

endmodule
